// File: rtl/gbf_sched_pkg.sv
// Shared definitions for the global-buffer load scheduler: stream indices
// and the burst FSM encoding.
package gbf_sched_pkg;
  localparam int PORT_DATAWIDTH = 128;
  localparam int NUM_STREAM     = 4;

  localparam logic [1:0] STRM_FLGWEI = 2'd0;
  localparam logic [1:0] STRM_WEI    = 2'd1;
  localparam logic [1:0] STRM_FLGACT = 2'd2;
  localparam logic [1:0] STRM_ACT    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_XFER = 2'd2
  } schedState_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester at or after rrPtr.
module rr_arbiter4
  import gbf_sched_pkg::*;
(
  input  logic [NUM_STREAM-1:0] req,
  input  logic [1:0]            rrPtr,
  output logic [NUM_STREAM-1:0] gnt,
  output logic [1:0]            gntIdx
);
  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_STREAM; i++) begin
      idx = rrPtr + 2'(i);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gntIdx      = idx;
      end
    end
  end
endmodule

// File: rtl/gbf_load_scheduler.sv
// Arbitrates GBF load requests, issues burst commands to the host and steers
// returned beats into the granted buffer with per-stream write addresses.
module gbf_load_scheduler
  import gbf_sched_pkg::*;
#(
  parameter int DATA_W    = PORT_DATAWIDTH,
  parameter int ADDR_W    = 9,
  parameter int BURST_LEN = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           Reset_WEI,
  input  logic                           Reset_ACT,
  input  logic [3:0]                     req,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [1:0]                     cmd_id,
  output logic [$clog2(BURST_LEN+1)-1:0] cmd_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic [3:0]                     gbf_enwr,
  output logic [DATA_W-1:0]              gbf_datwr,
  output logic [ADDR_W-1:0]              gbf_addrwr,
  output logic [3:0]                     grant,
  output logic                           burst_done
);
  localparam int LEN_W = $clog2(BURST_LEN+1);

  schedState_t                        state, stateNxt;
  logic [1:0]                         curId, rrPtr, arbIdx;
  logic [NUM_STREAM-1:0]              arbGnt, rewind;
  logic [LEN_W-1:0]                   beatCnt;
  logic [NUM_STREAM-1:0][ADDR_W-1:0]  addrQ;
  logic                               beat, lastBeat, cmdFire;

  rr_arbiter4 uArb (.req(req), .rrPtr(rrPtr), .gnt(arbGnt), .gntIdx(arbIdx));

  assign cmd_valid = (state == S_CMD);
  assign in_ready  = (state == S_XFER);
  assign cmd_id    = curId;
  assign cmd_len   = LEN_W'(BURST_LEN);
  assign cmdFire   = cmd_valid & cmd_ready;
  assign beat      = in_valid & in_ready;
  assign lastBeat  = beat && (beatCnt == LEN_W'(BURST_LEN-1));

  assign rewind[STRM_FLGWEI] = Reset_WEI;
  assign rewind[STRM_WEI]    = Reset_WEI;
  assign rewind[STRM_FLGACT] = Reset_ACT;
  assign rewind[STRM_ACT]    = Reset_ACT;

  always_comb begin
    stateNxt = state;
    case (state)
      S_IDLE:  if (req != '0) stateNxt = S_CMD;
      S_CMD:   if (cmdFire)   stateNxt = S_XFER;
      S_XFER:  if (lastBeat)  stateNxt = S_IDLE;
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNxt;
  end

  // req is only looked at in IDLE; a granted burst always runs to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curId   <= '0;
      rrPtr   <= '0;
      grant   <= '0;
      beatCnt <= '0;
    end else begin
      if (state == S_IDLE && req != '0) begin
        curId <= arbIdx;
        grant <= arbGnt;
      end
      if (cmdFire)   beatCnt <= '0;
      else if (beat) beatCnt <= beatCnt + LEN_W'(1);
      if (lastBeat) begin
        grant <= '0;
        rrPtr <= curId + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gbf_enwr   <= '0;
      gbf_datwr  <= '0;
      gbf_addrwr <= '0;
      burst_done <= 1'b0;
    end else begin
      gbf_enwr   <= '0;
      burst_done <= 1'b0;
      if (beat) begin
        gbf_enwr   <= 4'(1) << curId;
        gbf_datwr  <= in_data;
        gbf_addrwr <= addrQ[curId];
        burst_done <= lastBeat;
      end
    end
  end

  // Rewind beats an increment: the beat still writes the old address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ <= '0;
    end else begin
      for (int s = 0; s < NUM_STREAM; s++) begin
        if (rewind[s])                     addrQ[s] <= '0;
        else if (beat && curId == 2'(s))   addrQ[s] <= addrQ[s] + ADDR_W'(1);
      end
    end
  end
endmodule
